// File: rtl/ccm_pkg.sv
// ccm_pkg: register map, identity reset pattern and sign-magnitude helper for the colour-correction matrix.
package ccm_pkg;
    localparam logic [3:0] CCM_M00  = 4'd0;
    localparam logic [3:0] CCM_M01  = 4'd1;
    localparam logic [3:0] CCM_M02  = 4'd2;
    localparam logic [3:0] CCM_M10  = 4'd3;
    localparam logic [3:0] CCM_M11  = 4'd4;
    localparam logic [3:0] CCM_M12  = 4'd5;
    localparam logic [3:0] CCM_M20  = 4'd6;
    localparam logic [3:0] CCM_M21  = 4'd7;
    localparam logic [3:0] CCM_M22  = 4'd8;
    localparam logic [3:0] CCM_OFFR = 4'd9;
    localparam logic [3:0] CCM_OFFG = 4'd10;
    localparam logic [3:0] CCM_OFFB = 4'd11;

    // Coefficient indices that reset to 1.0; all others and the offsets reset to 0.
    localparam logic [8:0] CCM_IDENT_DIAG = 9'b100_010_001;

    // A zero magnitude negates to zero, so a signed zero needs no special case.
    function automatic logic [63:0] ccm_sm2tc(input logic sgn, input logic [63:0] mag);
        return sgn ? -mag : mag;
    endfunction
endpackage

// File: rtl/ccm_row_mac.sv
// ccm_row_mac: one output channel of the colour matrix -- multiply, sign, sum, round, offset, clamp.
module ccm_row_mac
    import ccm_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int MSIZE = 9,
    parameter int FSIZE = 6
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        en,
    input  logic [2:0][DSIZE-1:0]       x_i,
    input  logic [2:0][MSIZE-1:0]       m_i,
    input  logic [DSIZE:0]              off_i,
    output logic [DSIZE-1:0]            y_o,
    output logic                        sat_o
);
    localparam int PW = DSIZE + MSIZE - 1;
    localparam int TW = PW + 1;
    localparam int SW = TW + 2;
    localparam int ZW = SW + 1;
    localparam logic signed [ZW-1:0] HALF = ZW'(1 << (FSIZE - 1));
    localparam logic signed [ZW-1:0] MAXV = ZW'((1 << DSIZE) - 1);

    logic [2:0][PW-1:0]     p_q;
    logic [2:0]             s_q;
    logic [2:0][TW-1:0]     t_q, t_d;
    logic signed [SW-1:0]   sum_q, sum_d;
    logic [DSIZE:0]         off1_q, off2_q, off3_q;
    logic signed [ZW-1:0]   r_d, y_d, z_d;
    logic [DSIZE-1:0]       q_d;
    logic                   sat_d;

    always_comb begin
        for (int c = 0; c < 3; c++) t_d[c] = TW'(ccm_sm2tc(s_q[c], 64'(p_q[c])));
        sum_d = SW'($signed(t_q[0])) + SW'($signed(t_q[1])) + SW'($signed(t_q[2]));
        r_d   = ZW'(sum_q) + HALF;
        y_d   = r_d >>> FSIZE;
        z_d   = y_d + ZW'($signed(off3_q));
        sat_d = z_d[ZW-1] || (z_d > MAXV);
        q_d   = z_d[ZW-1] ? '0 : (z_d > MAXV) ? '1 : z_d[DSIZE-1:0];
    end

    always_ff @(posedge clock) begin
        if (en) begin
            for (int c = 0; c < 3; c++) begin
                p_q[c] <= PW'(m_i[c][MSIZE-2:0]) * PW'(x_i[c]);
                s_q[c] <= m_i[c][MSIZE-1];
            end
            t_q    <= t_d;
            sum_q  <= sum_d;
            off1_q <= off_i;
            off2_q <= off1_q;
            off3_q <= off2_q;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            y_o   <= '0;
            sat_o <= 1'b0;
        end else if (en) begin
            y_o   <= q_d;
            sat_o <= sat_d;
        end
    end
endmodule

// File: rtl/ccm_matrix_pipe.sv
// ccm_matrix_pipe: streaming 3x3 colour-correction matrix with offsets, shadow/active config and
// valid/ready flow control; the whole pipeline stalls together when the output is blocked.
module ccm_matrix_pipe
    import ccm_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int MSIZE = 9,
    parameter int FSIZE = 6,
    parameter int CFGW  = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [DSIZE-1:0] iR,
    input  logic [DSIZE-1:0] iG,
    input  logic [DSIZE-1:0] iB,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [DSIZE-1:0] Ro,
    output logic [DSIZE-1:0] Go,
    output logic [DSIZE-1:0] Bo,
    output logic [2:0]       o_sat,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [CFGW-1:0]  cfg_data,
    input  logic             cfg_commit
);
    localparam logic [MSIZE-1:0] ONE = MSIZE'(1 << FSIZE);

    logic [8:0][MSIZE-1:0]  msh_q, mact_q;
    logic [2:0][DSIZE:0]    osh_q, oact_q;
    logic [3:0]             v_q;
    logic                   en;
    logic [1:0]             oidx;
    logic [2:0][DSIZE-1:0]  x, y;
    logic [2:0]             sat;
    logic                   cfg_unused;

    assign en         = ~v_q[3] | o_ready;
    assign i_ready    = en;
    assign o_valid    = v_q[3];
    assign oidx       = cfg_addr[1:0] - 2'd1;
    assign x          = {iB, iG, iR};
    assign {Bo, Go, Ro} = y;
    assign o_sat      = sat;
    assign cfg_unused = ^cfg_data;

    // Commit copies the shadow as it was before any same-cycle write lands.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                msh_q[i]  <= CCM_IDENT_DIAG[i] ? ONE : '0;
                mact_q[i] <= CCM_IDENT_DIAG[i] ? ONE : '0;
            end
            osh_q  <= '0;
            oact_q <= '0;
            v_q    <= '0;
        end else begin
            if (cfg_commit) begin
                mact_q <= msh_q;
                oact_q <= osh_q;
            end
            if (cfg_we && cfg_addr <= CCM_M22) msh_q[cfg_addr] <= cfg_data[MSIZE-1:0];
            else if (cfg_we && cfg_addr >= CCM_OFFR && cfg_addr <= CCM_OFFB) osh_q[oidx] <= cfg_data[DSIZE:0];
            if (en) v_q <= {v_q[2:0], i_valid};
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        ccm_row_mac #(
            .DSIZE(DSIZE),
            .MSIZE(MSIZE),
            .FSIZE(FSIZE)
        ) u_mac (
            .clock(clock),
            .rst  (rst),
            .en   (en),
            .x_i  (x),
            .m_i  (mact_q[3*r +: 3]),
            .off_i(oact_q[r]),
            .y_o  (y[r]),
            .sat_o(sat[r])
        );
    end
endmodule

// File: tb/tb_ccm_matrix_pipe.sv
// tb_ccm_matrix_pipe: scenario tasks plus a randomized stream checked against an integer-arithmetic model.
module tb_ccm_matrix_pipe;
    logic        clock = 1'b0;
    logic        rst, i_valid, i_ready, o_valid, o_ready, cfg_we, cfg_commit;
    logic [7:0]  iR, iG, iB, Ro, Go, Bo;
    logic [2:0]  o_sat;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;

    int n_cmp = 0;
    int n_bad = 0;
    int sh_m[9], act_m[9], sh_o[3], act_o[3];

    ccm_matrix_pipe dut (
        .clock(clock), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .iR(iR), .iG(iG), .iB(iB), .o_valid(o_valid), .o_ready(o_ready),
        .Ro(Ro), .Go(Go), .Bo(Bo), .o_sat(o_sat), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit)
    );

    always #5 clock = ~clock;

    task automatic model_identity();
        for (int i = 0; i < 9; i++) begin
            sh_m[i]  = (i == 0 || i == 4 || i == 8) ? 64 : 0;
            act_m[i] = sh_m[i];
        end
        for (int i = 0; i < 3; i++) begin
            sh_o[i]  = 0;
            act_o[i] = 0;
        end
    endtask

    task automatic model_write(input int a, input int d);
        if (a < 9) sh_m[a] = d % 512;
        else if (a < 12) sh_o[a-9] = d % 512;
    endtask

    task automatic model_commit();
        act_m = sh_m;
        act_o = sh_o;
    endtask

    // Expected beat as {5'b0, sat[B,G,R], B, G, R} from the active model set.
    function automatic logic [31:0] ref_pix(input int r, input int g, input int b);
        int xs[3];
        int sum, m, mag, num, yv, off, z;
        logic [31:0] res;
        res = '0;
        xs[0] = r; xs[1] = g; xs[2] = b;
        for (int ch = 0; ch < 3; ch++) begin
            sum = 0;
            for (int c = 0; c < 3; c++) begin
                m   = act_m[ch*3+c];
                mag = m % 256;
                sum += ((m / 256) % 2 == 1 ? -mag : mag) * xs[c];
            end
            num = sum + 32;
            yv  = num / 64;
            if (num < 0 && num % 64 != 0) yv--;
            off = act_o[ch] >= 256 ? act_o[ch] - 512 : act_o[ch];
            z   = yv + off;
            res[8*ch +: 8] = 8'(z < 0 ? 0 : (z > 255 ? 255 : z));
            res[24+ch]     = (z < 0 || z > 255);
        end
        return res;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        model_identity();
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clock);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clock);
        cfg_we = 1'b0;
        model_write(int'(a), int'(d));
    endtask

    task automatic commit();
        @(negedge clock);
        cfg_commit = 1'b1;
        @(negedge clock);
        cfg_commit = 1'b0;
        model_commit();
    endtask

    task automatic xfer(input logic [7:0] r, g, b, output logic [31:0] pix, output int lat);
        @(negedge clock);
        iR = r; iG = g; iB = b; i_valid = 1'b1; o_ready = 1'b1;
        @(negedge clock);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        pix = {5'b0, o_sat, Bo, Go, Ro};
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0;
        cfg_addr = '0; cfg_data = '0; iR = '0; iG = '0; iB = '0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
        n_cmp++;
        if ({o_sat, Bo, Go, Ro} !== 27'd0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", {o_sat, Bo, Go, Ro}); end
        n_cmp++;
        if (i_ready !== 1'b1) begin n_bad++; $display("FAIL reset_i_ready: got %b expected 1", i_ready); end
        rst = 1'b0;
        model_identity();
    endtask

    task automatic test_identity();
        logic [31:0] pix;
        int lat;
        xfer(8'd200, 8'd100, 8'd50, pix, lat);
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL ident_latency: got %0d expected 4", lat); end
        n_cmp++;
        if (pix !== {5'b0, 3'b000, 8'd50, 8'd100, 8'd200}) begin
            n_bad++; $display("FAIL ident_pixel: got %h expected %h", pix, {5'b0, 3'b000, 8'd50, 8'd100, 8'd200});
        end
    endtask

    task automatic test_neg_clamp();
        logic [31:0] pix;
        int lat;
        cfg_write(4'd0, 16'd64);
        cfg_write(4'd1, 16'h140);
        commit();
        xfer(8'd10, 8'd20, 8'd0, pix, lat);
        n_cmp++;
        if (pix !== {5'b0, 3'b001, 8'd0, 8'd20, 8'd0}) begin
            n_bad++; $display("FAIL neg_clamp: got %h expected %h", pix, {5'b0, 3'b001, 8'd0, 8'd20, 8'd0});
        end
    endtask

    task automatic test_high_clamp_round();
        logic [31:0] pix;
        int lat;
        cfg_write(4'd1, 16'd64);
        cfg_write(4'd2, 16'd64);
        commit();
        xfer(8'd255, 8'd255, 8'd255, pix, lat);
        n_cmp++;
        if (pix !== {5'b0, 3'b001, 8'd255, 8'd255, 8'd255}) begin
            n_bad++; $display("FAIL high_clamp: got %h expected %h", pix, {5'b0, 3'b001, 8'd255, 8'd255, 8'd255});
        end
        cfg_write(4'd0, 16'd32);
        cfg_write(4'd1, 16'd0);
        cfg_write(4'd2, 16'd0);
        commit();
        xfer(8'd3, 8'd7, 8'd9, pix, lat);
        n_cmp++;
        if (pix !== {5'b0, 3'b000, 8'd9, 8'd7, 8'd2}) begin
            n_bad++; $display("FAIL round_half_up: got %h expected %h", pix, {5'b0, 3'b000, 8'd9, 8'd7, 8'd2});
        end
    endtask

    task automatic test_offset();
        logic [31:0] pix;
        int lat;
        do_reset();
        cfg_write(4'd10, 16'h1FB);
        commit();
        xfer(8'd0, 8'd3, 8'd0, pix, lat);
        n_cmp++;
        if (pix !== {5'b0, 3'b010, 8'd0, 8'd0, 8'd0}) begin
            n_bad++; $display("FAIL offset_low_clamp: got %h expected %h", pix, {5'b0, 3'b010, 8'd0, 8'd0, 8'd0});
        end
        xfer(8'd1, 8'd100, 8'd2, pix, lat);
        n_cmp++;
        if (pix !== {5'b0, 3'b000, 8'd2, 8'd95, 8'd1}) begin
            n_bad++; $display("FAIL offset_add: got %h expected %h", pix, {5'b0, 3'b000, 8'd2, 8'd95, 8'd1});
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] expq[$];
        logic [31:0] pix, prev, e;
        int nacc = 0, nrx = 0, cyc = 0;
        bit stalled, prev_stalled = 1'b0;
        do_reset();
        prev = '0;
        while (nrx < 10 && cyc < 60) begin
            @(negedge clock);
            o_ready = !(cyc >= 6 && cyc <= 8);
            i_valid = (nacc < 10);
            iR = 8'(nacc); iG = 8'($urandom); iB = 8'($urandom);
            #1;
            pix = {5'b0, o_sat, Bo, Go, Ro};
            if (prev_stalled) begin
                n_cmp++;
                if (pix !== prev) begin n_bad++; $display("FAIL bp_stable: got %h expected %h", pix, prev); end
            end
            stalled = o_valid && !o_ready;
            if (stalled) begin
                n_cmp++;
                if (i_ready !== 1'b0) begin n_bad++; $display("FAIL bp_i_ready: got %b expected 0", i_ready); end
            end
            if (i_valid && i_ready) begin
                expq.push_back(ref_pix(iR, iG, iB));
                nacc++;
            end
            if (o_valid && o_ready) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra_beat: got %h expected none", pix);
                end else begin
                    e = expq.pop_front();
                    if (pix !== e) begin n_bad++; $display("FAIL bp_beat%0d: got %h expected %h", nrx, pix, e); end
                end
                nrx++;
            end
            prev = pix;
            prev_stalled = stalled;
            cyc++;
        end
        i_valid = 1'b0; o_ready = 1'b1;
        n_cmp++;
        if (nrx !== 10) begin n_bad++; $display("FAIL bp_count: got %0d expected 10", nrx); end
    endtask

    task automatic test_commit_mid();
        logic [31:0] exps[4], outs[4];
        int nacc = 0, nrx = 0, cyc = 0;
        do_reset();
        cfg_write(4'd0, 16'd0);
        cfg_write(4'd2, 16'd64);
        cfg_write(4'd6, 16'd64);
        cfg_write(4'd8, 16'd0);
        while (nrx < 4 && cyc < 30) begin
            @(negedge clock);
            o_ready = 1'b1;
            i_valid = (nacc < 4);
            iR = 8'(10 + nacc); iG = 8'(20 + nacc); iB = 8'(30 + nacc);
            cfg_commit = (nacc == 1);
            #1;
            if (i_valid && i_ready) begin
                exps[nacc] = ref_pix(iR, iG, iB);
                nacc++;
            end
            if (cfg_commit) model_commit();
            if (o_valid && o_ready) begin
                outs[nrx] = {5'b0, o_sat, Bo, Go, Ro};
                nrx++;
            end
            cyc++;
        end
        @(negedge clock);
        i_valid = 1'b0; cfg_commit = 1'b0;
        n_cmp++;
        if (nrx !== 4) begin n_bad++; $display("FAIL commit_count: got %0d expected 4", nrx); end
        for (int i = 0; i < nrx; i++) begin
            n_cmp++;
            if (outs[i] !== exps[i]) begin n_bad++; $display("FAIL commit_beat%0d: got %h expected %h", i, outs[i], exps[i]); end
        end
        if (nrx == 4) begin
            n_cmp++;
            if (outs[1] !== {5'b0, 3'b000, 8'd31, 8'd21, 8'd11}) begin
                n_bad++; $display("FAIL commit_old_set: got %h expected %h", outs[1], {5'b0, 3'b000, 8'd31, 8'd21, 8'd11});
            end
            n_cmp++;
            if (outs[2] !== {5'b0, 3'b000, 8'd12, 8'd22, 8'd32}) begin
                n_bad++; $display("FAIL commit_new_set: got %h expected %h", outs[2], {5'b0, 3'b000, 8'd12, 8'd22, 8'd32});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] pix;
        int lat, nv = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            i_valid = 1'b1; o_ready = 1'b1;
            iR = 8'(60 + i); iG = 8'(70 + i); iB = 8'(80 + i);
        end
        @(negedge clock);
        i_valid = 1'b0; rst = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_o_valid: got %b expected 0", o_valid); end
        n_cmp++;
        if ({o_sat, Bo, Go, Ro} !== 27'd0) begin n_bad++; $display("FAIL midrst_outputs: got %h expected 0", {o_sat, Bo, Go, Ro}); end
        rst = 1'b0;
        model_identity();
        repeat (8) begin
            @(negedge clock);
            if (o_valid) nv++;
        end
        n_cmp++;
        if (nv !== 0) begin n_bad++; $display("FAIL midrst_ghost: got %0d valid cycles expected 0", nv); end
        xfer(8'd7, 8'd8, 8'd9, pix, lat);
        n_cmp++;
        if (pix !== {5'b0, 3'b000, 8'd9, 8'd8, 8'd7}) begin
            n_bad++; $display("FAIL midrst_active_ident: got %h expected %h", pix, {5'b0, 3'b000, 8'd9, 8'd8, 8'd7});
        end
        commit();
        xfer(8'd40, 8'd50, 8'd60, pix, lat);
        n_cmp++;
        if (pix !== {5'b0, 3'b000, 8'd60, 8'd50, 8'd40}) begin
            n_bad++; $display("FAIL midrst_shadow_ident: got %h expected %h", pix, {5'b0, 3'b000, 8'd60, 8'd50, 8'd40});
        end
    endtask

    task automatic test_random();
        logic [31:0] expq[$];
        logic [31:0] pix, e;
        int nacc = 0, nrx = 0, cyc = 0;
        for (int i = 0; i < 12; i++) cfg_write(4'($urandom), 16'($urandom));
        commit();
        while (nrx < 30 && cyc < 400) begin
            @(negedge clock);
            o_ready    = ($urandom_range(0, 3) != 0);
            i_valid    = (nacc < 30) && ($urandom_range(0, 3) != 0);
            iR = 8'($urandom); iG = 8'($urandom); iB = 8'($urandom);
            cfg_we     = ($urandom_range(0, 3) == 0);
            cfg_addr   = 4'($urandom);
            cfg_data   = 16'($urandom);
            cfg_commit = ($urandom_range(0, 7) == 0);
            #1;
            pix = {5'b0, o_sat, Bo, Go, Ro};
            if (i_valid && i_ready) begin
                expq.push_back(ref_pix(iR, iG, iB));
                nacc++;
            end
            if (o_valid && o_ready) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++; $display("FAIL rand_extra_beat: got %h expected none", pix);
                end else begin
                    e = expq.pop_front();
                    if (pix !== e) begin n_bad++; $display("FAIL rand_beat%0d: got %h expected %h", nrx, pix, e); end
                end
                nrx++;
            end
            if (cfg_commit) model_commit();
            if (cfg_we) model_write(int'(cfg_addr), int'(cfg_data));
            cyc++;
        end
        @(negedge clock);
        i_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; o_ready = 1'b1;
        n_cmp++;
        if (nrx !== 30) begin n_bad++; $display("FAIL rand_count: got %0d expected 30", nrx); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_neg_clamp();
        test_high_clamp_round();
        test_offset();
        test_backpressure();
        test_commit_mid();
        test_reset_mid();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
